// File: rtl/avalon_arb_pack.sv
// Shared types and limits for the Avalon-ST packet arbiter and its round-robin picker.
package avalon_arb_pack;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_NUM_INPUTS  = 16;
    localparam int unsigned STATS_CNT_WIDTH = 16;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_rr_picker.sv
// Pure combinational round-robin picker: first requester strictly after last_grant, wrapping.
module avalon_rr_picker
    import avalon_arb_pack::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    localparam int unsigned IdxW      = idx_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [IdxW-1:0]       last_grant_i,
    output logic                  any_req_o,
    output logic [IdxW-1:0]       winner_o
);

    logic [NUM_INPUTS-1:0] hi_mask;
    logic [NUM_INPUTS-1:0] hi_req;
    logic                  hi_any;

    function automatic logic [IdxW-1:0] first_set(input logic [NUM_INPUTS-1:0] v);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IdxW'(i);
            end
        end
        return idx;
    endfunction

    // Inputs above the last winner get first chance; the rest only if none of those request.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            hi_mask[i] = (IdxW'(i) > last_grant_i);
        end
    end

    assign hi_req    = req_i & hi_mask;
    assign hi_any    = |hi_req;
    assign any_req_o = |req_i;
    assign winner_o  = hi_any ? first_set(hi_req) : first_set(req_i);

endmodule

// File: rtl/avalon_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST sink among NUM_INPUTS sources.
// Optional per-input accepted-packet counters are built when AVALON_PKT_ARB_STATS_EN is defined.
module avalon_pkt_arbiter
    import avalon_arb_pack::*;
#(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned NUM_INPUTS          = 4,
    localparam int unsigned DataW              = 8 * DATA_WIDTH_IN_BYTES,
    localparam int unsigned EmptyW             = idx_width(DATA_WIDTH_IN_BYTES),
    localparam int unsigned IdxW               = idx_width(NUM_INPUTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_INPUTS-1:0][DataW-1:0]       in_data_i,
    input  logic [NUM_INPUTS-1:0][EmptyW-1:0]      in_empty_i,
    input  logic [NUM_INPUTS-1:0]                  in_sop_i,
    input  logic [NUM_INPUTS-1:0]                  in_eop_i,
    input  logic [NUM_INPUTS-1:0]                  in_valid_i,
    output logic [NUM_INPUTS-1:0]                  in_rdy_o,
    output logic [DataW-1:0]                       out_data_o,
    output logic [EmptyW-1:0]                      out_empty_o,
    output logic                                   out_sop_o,
    output logic                                   out_eop_o,
    output logic                                   out_valid_o,
    input  logic                                   out_rdy_i,
    output logic [IdxW-1:0]                        grant_id_o,
`ifdef AVALON_PKT_ARB_STATS_EN
    output logic [NUM_INPUTS-1:0][STATS_CNT_WIDTH-1:0] pkt_cnt_o,
`endif
    output logic                                   busy_o
);

    arb_state_t            state_q, state_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    logic [NUM_INPUTS-1:0] req;
    logic                  any_req;
    logic [IdxW-1:0]       winner;
    logic                  beat_accept;
    logic                  eop_accept;

    // Only a valid SOP beat may open arbitration; stray mid-packet beats never request.
    assign req = in_valid_i & in_sop_i;

    avalon_rr_picker #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_picker (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .any_req_o    (any_req),
        .winner_o     (winner)
    );

    assign beat_accept = out_valid_o & out_rdy_i;
    assign eop_accept  = beat_accept & out_eop_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = LOCKED;
                    grant_d      = winner;
                    last_grant_d = winner;
                end
            end
            LOCKED: begin
                if (eop_accept) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Locked: zero-latency pass-through of the granted source; everyone else sees rdy=0.
    always_comb begin
        out_data_o  = '0;
        out_empty_o = '0;
        out_sop_o   = 1'b0;
        out_eop_o   = 1'b0;
        out_valid_o = 1'b0;
        in_rdy_o    = '0;
        if (state_q == LOCKED) begin
            out_data_o        = in_data_i[grant_q];
            out_empty_o       = in_empty_i[grant_q];
            out_sop_o         = in_sop_i[grant_q];
            out_eop_o         = in_eop_i[grant_q];
            out_valid_o       = in_valid_i[grant_q];
            in_rdy_o[grant_q] = out_rdy_i;
        end
    end

    assign busy_o     = (state_q == LOCKED);
    assign grant_id_o = grant_q;

`ifdef AVALON_PKT_ARB_STATS_EN
    logic [NUM_INPUTS-1:0][STATS_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (eop_accept) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + STATS_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
